// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard/control unit.
// Covers the result-source and forward-select codes and the memory-wait FSM states.
package pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
// A clear in the same cycle as an increment leaves the counter at zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/control unit for the 5-stage core: forwarding, load-use interlock, branch flush,
// DMEM wait-state freeze with sticky timeout, and saturating performance counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter bit LU_STALL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [1:0]        ResultSrc_E,
    input  logic              RegWrite_E,
    input  logic              PCSrc_E,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              DMemReq_M,
    input  logic              DMemReady_M,
    input  logic              CntClr,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Stall_W,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              MemTimeout,
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output mem_state_t        mem_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic              mem_freeze;
    logic              lu_hazard;
    logic              flush_applied;
    logic              any_stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    mem_state_t        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              set_timeout;

    assign mem_freeze = DMemReq_M && !DMemReady_M;
    assign lu_hazard  = LU_STALL_EN && (ResultSrc_E == RES_MEM) && RegWrite_E &&
                        (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // M-stage result is younger than W-stage, so it takes precedence; x0 is never forwarded.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs1_E))      fwd_a = FWD_M;
        else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_E)) fwd_a = FWD_W;
        if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs2_E))      fwd_b = FWD_M;
        else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_E)) fwd_b = FWD_W;
    end

    always_comb begin
        ForwardA_E    = rst ? FWD_RF : fwd_a;
        ForwardB_E    = rst ? FWD_RF : fwd_b;
        Stall_F       = 1'b0;
        Stall_D       = 1'b0;
        Stall_E       = 1'b0;
        Stall_M       = 1'b0;
        Stall_W       = 1'b0;
        Flush_D       = 1'b0;
        Flush_E       = 1'b0;
        flush_applied = 1'b0;
        if (rst) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (mem_freeze) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Stall_W = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D       = 1'b1;
            Flush_E       = 1'b1;
            flush_applied = 1'b1;
        end else if (lu_hazard) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    // Wait-state tracking only feeds the timeout flag; stalls come straight from the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_state  <= MEM_IDLE;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            mem_state <= state_next;
            wait_cnt  <= wait_next;
            if (set_timeout) MemTimeout <= 1'b1;
        end
    end

    always_comb begin
        state_next = mem_state;
        wait_next  = wait_cnt;
        case (mem_state)
            MEM_IDLE: begin
                if (mem_freeze) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_freeze) begin
                    if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + 1'b1;
                end else begin
                    state_next = MEM_IDLE;
                    wait_next  = '0;
                end
            end
            default: begin
                state_next = MEM_IDLE;
                wait_next  = '0;
            end
        endcase
        set_timeout = (wait_next == WAIT_MAX);
    end

    assign any_stall = Stall_F | Stall_D | Stall_E | Stall_M | Stall_W;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk), .rst (rst), .clr (CntClr), .inc (1'b1),          .q (CycleCnt)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk), .rst (rst), .clr (CntClr), .inc (any_stall),     .q (StallCnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .clr (CntClr), .inc (flush_applied), .q (FlushCnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: one instance with a short timeout and wide counters, one with
// the load-use interlock disabled and 4-bit counters, both driven by the same inputs.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic [1:0] ResultSrc_E;
    logic       RegWrite_E, PCSrc_E, RegWrite_M, RegWrite_W;
    logic       DMemReq_M, DMemReady_M, CntClr;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_sf, a_sd, a_se, a_sm, a_sw, a_fd, a_fe, a_to;
    logic        b_sf, b_sd, b_se, b_sm, b_sw, b_fd, b_fe, b_to;
    logic [31:0] a_cyc, a_stl, a_fls;
    logic [3:0]  b_cyc, b_stl, b_fls;
    mem_state_t  a_st, b_st;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;

    // Control vector layout: {ForwardA, ForwardB, Stall_F..W, Flush_D, Flush_E}
    localparam logic [10:0] V_IDLE = 11'b00_00_00000_00;
    localparam logic [10:0] V_RST  = 11'b00_00_00000_11;
    localparam logic [10:0] V_LU   = 11'b00_00_11000_01;
    localparam logic [10:0] V_BR   = 11'b00_00_00000_11;
    localparam logic [10:0] V_FRZ  = 11'b00_00_11111_00;

    typedef struct packed {
        logic       rwm;
        logic [4:0] rdm;
        logic       rww;
        logic [4:0] rdw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] fwd;
    } fwd_case_t;

    pipeline_ctrl #(.REG_AW(5), .CNT_W(32), .MEM_TIMEOUT(4), .LU_STALL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E), .RegWrite_E(RegWrite_E), .PCSrc_E(PCSrc_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M), .CntClr(CntClr),
        .ForwardA_E(a_fa), .ForwardB_E(a_fb), .Stall_F(a_sf), .Stall_D(a_sd), .Stall_E(a_se),
        .Stall_M(a_sm), .Stall_W(a_sw), .Flush_D(a_fd), .Flush_E(a_fe), .MemTimeout(a_to),
        .CycleCnt(a_cyc), .StallCnt(a_stl), .FlushCnt(a_fls), .mem_state(a_st)
    );

    pipeline_ctrl #(.REG_AW(5), .CNT_W(4), .MEM_TIMEOUT(64), .LU_STALL_EN(1'b0)) u_nolu (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E), .RegWrite_E(RegWrite_E), .PCSrc_E(PCSrc_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M), .CntClr(CntClr),
        .ForwardA_E(b_fa), .ForwardB_E(b_fb), .Stall_F(b_sf), .Stall_D(b_sd), .Stall_E(b_se),
        .Stall_M(b_sm), .Stall_W(b_sw), .Flush_D(b_fd), .Flush_E(b_fe), .MemTimeout(b_to),
        .CycleCnt(b_cyc), .StallCnt(b_stl), .FlushCnt(b_fls), .mem_state(b_st)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] a_vec();
        return {a_fa, a_fb, a_sf, a_sd, a_se, a_sm, a_sw, a_fd, a_fe};
    endfunction

    function automatic logic [10:0] b_vec();
        return {b_fa, b_fb, b_sf, b_sd, b_se, b_sm, b_sw, b_fd, b_fe};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0; Rd_M = '0; Rd_W = '0;
        ResultSrc_E = RES_ALU; RegWrite_E = 1'b0; PCSrc_E = 1'b0;
        RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        DMemReq_M = 1'b0; DMemReady_M = 1'b0; CntClr = 1'b0;
    endtask

    task automatic set_load_use();
        ResultSrc_E = RES_MEM; RegWrite_E = 1'b1; Rd_E = 5'd7; Rs2_D = 5'd7;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        RegWrite_M = 1'b1; Rd_M = 5'd5; Rs1_E = 5'd5; DMemReq_M = 1'b1;
        set_load_use();
        Rs1_D = 5'd7;
        exp_q.push_back(V_RST);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL reset_ctrl: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        total_cnt++;
        if (b_vec() !== V_RST) $display("FAIL reset_ctrl_nolu: got %b want %b", b_vec(), V_RST);
        else pass_cnt++;
        total_cnt++;
        if ({a_to, a_cyc, a_stl, a_fls} !== '0) $display("FAIL reset_regs: to=%b cyc=%0d stl=%0d fls=%0d want 0", a_to, a_cyc, a_stl, a_fls);
        else pass_cnt++;
        total_cnt++;
        if (a_st !== MEM_IDLE) $display("FAIL reset_state: got %0d want %0d", a_st, MEM_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_forwarding();
        fwd_case_t tbl[5];
        logic [1:0] ea, eb;
        tbl[0] = '{1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  5'd0,  4'b1000};
        tbl[1] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  4'b0000};
        tbl[2] = '{1'b0, 5'd3,  1'b1, 5'd3,  5'd3,  5'd3,  4'b0101};
        tbl[3] = '{1'b1, 5'd9,  1'b1, 5'd4,  5'd4,  5'd9,  4'b0110};
        tbl[4] = '{1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 5'd31, 4'b1010};
        do_reset();
        for (int i = 0; i < 5 + 24; i++) begin
            if (i < 5) begin
                RegWrite_M = tbl[i].rwm; Rd_M = tbl[i].rdm; RegWrite_W = tbl[i].rww;
                Rd_W = tbl[i].rdw; Rs1_E = tbl[i].rs1; Rs2_E = tbl[i].rs2;
                exp_q.push_back({tbl[i].fwd, 7'b0});
            end else begin
                RegWrite_M = 1'($urandom_range(0, 1)); Rd_M = 5'($urandom_range(0, 3));
                RegWrite_W = 1'($urandom_range(0, 1)); Rd_W = 5'($urandom_range(0, 3));
                Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
                ea = (RegWrite_M && Rd_M != 0 && Rd_M == Rs1_E) ? FWD_M :
                     (RegWrite_W && Rd_W != 0 && Rd_W == Rs1_E) ? FWD_W : FWD_RF;
                eb = (RegWrite_M && Rd_M != 0 && Rd_M == Rs2_E) ? FWD_M :
                     (RegWrite_W && Rd_W != 0 && Rd_W == Rs2_E) ? FWD_W : FWD_RF;
                exp_q.push_back({ea, eb, 7'b0});
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (a_vec() !== exp_v) $display("FAIL fwd_%0d: got %b want %b", i, a_vec(), exp_v);
            else pass_cnt++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        exp_q.push_back(V_LU);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL load_use: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        total_cnt++;
        if (b_vec() !== V_IDLE) $display("FAIL load_use_disabled: got %b want %b", b_vec(), V_IDLE);
        else pass_cnt++;
        step();
        clear_inputs();
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL load_use_bubble_end: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        total_cnt++;
        if (a_stl !== 32'd1) $display("FAIL load_use_stallcnt: got %0d want 1", a_stl);
        else pass_cnt++;
        total_cnt++;
        if (b_stl !== 4'd0) $display("FAIL load_use_stallcnt_nolu: got %0d want 0", b_stl);
        else pass_cnt++;
        // A load to x0, and an ALU op with a matching Rd, must not interlock.
        step();
        ResultSrc_E = RES_MEM; RegWrite_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0;
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL load_use_x0: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        step();
        ResultSrc_E = RES_ALU; Rd_E = 5'd7; Rs1_D = 5'd7;
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL load_use_alu: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        step();
        clear_inputs();
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        set_load_use();
        PCSrc_E = 1'b1;
        exp_q.push_back(V_BR);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL branch_lu: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        step();
        clear_inputs();
        @(negedge clk);
        total_cnt++;
        if (a_fls !== 32'd1 || a_stl !== 32'd0) $display("FAIL branch_cnts: flush=%0d stall=%0d want 1/0", a_fls, a_stl);
        else pass_cnt++;
        step();
    endtask

    task automatic test_mem_freeze();
        do_reset();
        set_load_use();
        PCSrc_E = 1'b1; DMemReq_M = 1'b1; DMemReady_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_FRZ);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (a_vec() !== exp_v) $display("FAIL freeze_%0d: got %b want %b", i, a_vec(), exp_v);
            else pass_cnt++;
            total_cnt++;
            if (a_st !== ((i == 0) ? MEM_IDLE : MEM_WAIT)) $display("FAIL freeze_state_%0d: got %0d", i, a_st);
            else pass_cnt++;
            step();
        end
        clear_inputs();
        DMemReq_M = 1'b1; DMemReady_M = 1'b1;
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (a_vec() !== exp_v) $display("FAIL freeze_ready: got %b want %b", a_vec(), exp_v);
        else pass_cnt++;
        step();
        clear_inputs();
        @(negedge clk);
        total_cnt++;
        if (a_stl !== 32'd3 || a_fls !== 32'd0 || a_to !== 1'b0)
            $display("FAIL freeze_after: stall=%0d flush=%0d to=%b want 3/0/0", a_stl, a_fls, a_to);
        else pass_cnt++;
        total_cnt++;
        if (a_st !== MEM_IDLE) $display("FAIL freeze_idle: got %0d want %0d", a_st, MEM_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (b_stl !== 4'd3) $display("FAIL freeze_stallcnt_nolu: got %0d want 3", b_stl);
        else pass_cnt++;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        DMemReq_M = 1'b1; DMemReady_M = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(V_FRZ);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (a_vec() !== exp_v) $display("FAIL timeout_freeze_%0d: got %b want %b", i, a_vec(), exp_v);
            else pass_cnt++;
            total_cnt++;
            if (a_to !== (i >= 5)) $display("FAIL timeout_cycle_%0d: got %b want %b", i, a_to, (i >= 5));
            else pass_cnt++;
            step();
        end
        DMemReady_M = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (a_to !== 1'b1) $display("FAIL timeout_ready: got %b want 1", a_to);
        else pass_cnt++;
        step();
        clear_inputs();
        @(negedge clk);
        total_cnt++;
        if (a_to !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", a_to);
        else pass_cnt++;
        total_cnt++;
        if (b_to !== 1'b0) $display("FAIL timeout_long_limit: got %b want 0", b_to);
        else pass_cnt++;
        // Reset arriving mid-wait must act immediately, without a clock edge.
        step();
        DMemReq_M = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (a_st !== MEM_IDLE || a_to !== 1'b0) $display("FAIL midwait_reset: state=%0d to=%b want 0/0", a_st, a_to);
        else pass_cnt++;
        total_cnt++;
        if (a_vec() !== V_RST) $display("FAIL midwait_reset_ctrl: got %b want %b", a_vec(), V_RST);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_counter_sat();
        do_reset();
        repeat (20) step();
        @(negedge clk);
        total_cnt++;
        if (b_cyc !== 4'd15) $display("FAIL cnt_saturate: got %0d want 15", b_cyc);
        else pass_cnt++;
        total_cnt++;
        if (a_cyc !== 32'd20) $display("FAIL cnt_wide: got %0d want 20", a_cyc);
        else pass_cnt++;
        CntClr = 1'b1;
        step();
        CntClr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (b_cyc !== 4'd0 || a_cyc !== 32'd0) $display("FAIL cnt_clear: got %0d/%0d want 0/0", b_cyc, a_cyc);
        else pass_cnt++;
        step();
        @(negedge clk);
        total_cnt++;
        if (b_cyc !== 4'd1 || a_cyc !== 32'd1) $display("FAIL cnt_restart: got %0d/%0d want 1/1", b_cyc, a_cyc);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_over_load_use();
        test_mem_freeze();
        test_timeout();
        test_counter_sat();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
